// File: rtl/line_mem_responder_if.sv
// Line access request type and the request/response port bundle shared by
// initiators (master) and the line memory responder (slave).
package line_acc_pkg;
  typedef struct packed {
    logic [31:0]  addr;
    logic         rqt;   // 1 = write, 0 = read
    logic [15:0]  wmsk;  // byte enables for writes
    logic [127:0] dat;
  } line_acc_req;
endpackage

interface line_mem_responder_if;
  import line_acc_pkg::*;

  logic        prt_tx_rp;
  line_acc_req prt_tx_req;
  logic        prt_tx_ra;
  logic        prt_rx_rp;
  line_acc_req prt_rx_req;
  logic        prt_rx_ra;

  modport master (
    output prt_tx_rp, prt_tx_req, prt_rx_ra,
    input  prt_tx_ra, prt_rx_rp, prt_rx_req
  );

  modport slave (
    input  prt_tx_rp, prt_tx_req, prt_rx_ra,
    output prt_tx_ra, prt_rx_rp, prt_rx_req
  );
endinterface

// File: rtl/line_mem_responder.sv
// Single-outstanding 16-byte line memory responder. Accepts one request,
// waits LATENCY cycles, then commits a masked write or returns the read line
// and holds it until the initiator accepts it.
module line_mem_responder
  import line_acc_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  line_mem_responder_if.slave  prt,
  output logic                 busy,
  output logic                 addr_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  line_acc_req req, req_nx;
  line_acc_req rx_req, rx_req_nx;
  logic        tx_ra, tx_ra_nx;
  logic        rx_rp, rx_rp_nx;
  logic        err_nx;
  logic        busy_nx;
  logic        wr_en;

  logic [127:0]     store [DEPTH_LINES];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [127:0]     line;
  logic [127:0]     merged;

  // Line index comes from addr[31:4]; the byte offset is ignored.
  assign idx      = req.addr[IDX_W+3:4];
  assign in_range = ({4'b0000, req.addr[31:4]} < 32'(DEPTH_LINES));
  assign line     = store[idx];

  assign prt.prt_tx_ra  = tx_ra;
  assign prt.prt_rx_rp  = rx_rp;
  assign prt.prt_rx_req = rx_req;

  // Byte-wise merge of the latched write data into the current line.
  always_comb begin
    merged = line;
    for (int i = 0; i < 16; i++) begin
      if (req.wmsk[i]) begin
        merged[8*i +: 8] = req.dat[8*i +: 8];
      end else begin
        merged[8*i +: 8] = line[8*i +: 8];
      end
    end
  end

  // Next-state and next-output decode for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_nx    = req;
    tx_ra_nx  = 1'b0;
    rx_rp_nx  = rx_rp;
    rx_req_nx = rx_req;
    err_nx    = addr_err;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        // rp is ignored while ra is still high so a slow-dropping initiator
        // is never accepted twice.
        if (prt.prt_tx_rp && !tx_ra) begin
          req_nx   = prt.prt_tx_req;
          tx_ra_nx = 1'b1;
          cnt_nx   = CNT_W'(LATENCY - 1);
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (req.rqt) begin
            if (in_range) begin
              wr_en = 1'b1;
            end else begin
              err_nx = 1'b1;
            end
            state_nx = IDLE;
          end else begin
            rx_rp_nx       = 1'b1;
            rx_req_nx.addr = {req.addr[31:4], 4'b0000};
            rx_req_nx.rqt  = 1'b0;
            rx_req_nx.wmsk = 16'h0000;
            if (in_range) begin
              rx_req_nx.dat = line;
            end else begin
              rx_req_nx.dat = 128'd0;
              err_nx        = 1'b1;
            end
            state_nx = RESP;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (prt.prt_rx_ra) begin
          rx_rp_nx  = 1'b0;
          rx_req_nx = '0;
          state_nx  = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Control state and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req      <= '0;
      tx_ra    <= 1'b0;
      rx_rp    <= 1'b0;
      rx_req   <= '0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      req      <= req_nx;
      tx_ra    <= tx_ra_nx;
      rx_rp    <= rx_rp_nx;
      rx_req   <= rx_req_nx;
      busy     <= busy_nx;
      addr_err <= err_nx;
    end
  end

  // Backing line store: cleared by reset, written only on a write commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_LINES; i++) begin
        store[i] <= '0;
      end
    end else if (wr_en) begin
      store[idx] <= merged;
    end else begin
      store[idx] <= store[idx];
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed scenarios plus a
// randomized read/write mix checked against a byte-level line model.
module tb_line_mem_responder;
  import line_acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy3, err3, busy1, err1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ra_cnt1 = 0;
  int   rsp_cnt1 = 0;

  logic [127:0] mdl [256];
  bit           mdl_err;

  line_mem_responder_if if3 ();
  line_mem_responder_if if1 ();

  line_mem_responder #(.DEPTH_LINES(256), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .prt(if3.slave), .busy(busy3), .addr_err(err3)
  );
  line_mem_responder #(.DEPTH_LINES(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .prt(if1.slave), .busy(busy1), .addr_err(err1)
  );

  always #5 clk = ~clk;

  // Event counters for the LATENCY=1 instance.
  always @(posedge clk) begin
    if (if1.prt_tx_ra === 1'b1) ra_cnt1++;
    if (if1.prt_rx_rp === 1'b1 && if1.prt_rx_ra === 1'b1) rsp_cnt1++;
  end

  function automatic logic [127:0] mdl_read(input logic [31:0] a);
    if (a[31:4] < 28'd256) return mdl[a[11:4]];
    return 128'd0;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
    logic [127:0] ln;
    if (a[31:4] >= 28'd256) begin
      mdl_err = 1'b1;
    end else begin
      ln = mdl[a[11:4]];
      for (int b = 0; b < 16; b++)
        if (m[b]) ln[8*b +: 8] = d[8*b +: 8];
      mdl[a[11:4]] = ln;
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 256; i++) mdl[i] = 128'd0;
    mdl_err = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits (bounded) for tx_ra on the LATENCY=3 port; k = edges waited, -1 on timeout.
  task automatic wait_accept3(output int k);
    k = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (if3.prt_tx_ra === 1'b1) begin k = c; break; end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d,
                          output int lat, output bit pulse_ok);
    int k;
    lat = -1; pulse_ok = 1'b0;
    if3.prt_tx_req.addr = a; if3.prt_tx_req.rqt = 1'b1;
    if3.prt_tx_req.wmsk = m; if3.prt_tx_req.dat = d;
    if3.prt_tx_rp = 1'b1;
    wait_accept3(k);
    if3.prt_tx_rp = 1'b0;
    if (k > 0) begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (c == 1) pulse_ok = (if3.prt_tx_ra === 1'b0);
        if (busy3 === 1'b0) begin lat = c; break; end
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, output int lat,
                         output line_acc_req resp, output bit stable, output bit cleared);
    int k;
    lat = -1; resp = '0; stable = 1'b0; cleared = 1'b0;
    if3.prt_tx_req.addr = a; if3.prt_tx_req.rqt = 1'b0;
    if3.prt_tx_req.wmsk = 16'($urandom); if3.prt_tx_req.dat = rnd128();
    if3.prt_tx_rp = 1'b1;
    wait_accept3(k);
    if3.prt_tx_rp = 1'b0;
    if (k > 0) begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (if3.prt_rx_rp === 1'b1) begin lat = c; break; end
      end
      if (lat > 0) begin
        resp = if3.prt_rx_req;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          if (if3.prt_rx_rp !== 1'b1 || if3.prt_rx_req !== resp) stable = 1'b0;
        end
        if3.prt_rx_ra = 1'b1;
        @(posedge clk); #1;
        if3.prt_rx_ra = 1'b0;
        cleared = (if3.prt_rx_rp === 1'b0) && (if3.prt_rx_req === '0) && (busy3 === 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({if3.prt_tx_ra, if3.prt_rx_rp, busy3, err3} !== 4'b0000 || if3.prt_rx_req !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ra=%b rp=%b busy=%b err=%b req=%h, want all zero",
               if3.prt_tx_ra, if3.prt_rx_rp, busy3, err3, if3.prt_rx_req);
    end
    rst = 1'b0;
    mdl_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    int k, lat;
    line_acc_req r;
    bit st, cl;
    if3.prt_tx_req.addr = 32'h0000_0050; if3.prt_tx_req.rqt = 1'b1;
    if3.prt_tx_req.wmsk = 16'hFFFF;      if3.prt_tx_req.dat = rnd128();
    if3.prt_tx_rp = 1'b1;
    wait_accept3(k);
    if3.prt_tx_rp = 1'b0;
    n_cmp++;
    if (k <= 0) begin n_bad++; $display("FAIL midflight_accept: got %0d, want >0", k); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({if3.prt_tx_ra, if3.prt_rx_rp, busy3, err3} !== 4'b0000 || if3.prt_rx_req !== '0) begin
      n_bad++;
      $display("FAIL midflight_rst_outputs: got ra=%b rp=%b busy=%b err=%b, want 0",
               if3.prt_tx_ra, if3.prt_rx_rp, busy3, err3);
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    mdl_clear();
    do_read(32'h0000_0050, 0, lat, r, st, cl);
    n_cmp++;
    if (r.dat !== 128'd0 || lat != 3) begin
      n_bad++; $display("FAIL midflight_no_commit: got dat=%h lat=%0d, want 0 / 3", r.dat, lat);
    end
  endtask

  task automatic test_full_write_read();
    int lat;
    bit p, st, cl;
    line_acc_req r;
    logic [127:0] d;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_write(32'h0000_0040, 16'hFFFF, d, lat, p);
    mdl_write(32'h0000_0040, 16'hFFFF, d);
    n_cmp++;
    if (lat != 3 || !p) begin n_bad++; $display("FAIL full_write: got lat=%0d pulse=%b, want 3/1", lat, p); end
    do_read(32'h0000_0040, 0, lat, r, st, cl);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL full_read_lat: got %0d, want 3", lat); end
    n_cmp++;
    if (r.dat !== d || r.addr !== 32'h40 || r.rqt !== 1'b0 || r.wmsk !== 16'h0) begin
      n_bad++; $display("FAIL full_read_data: got addr=%h dat=%h, want 40 / %h", r.addr, r.dat, d);
    end
    n_cmp++;
    if (!cl) begin n_bad++; $display("FAIL full_read_clear: got %b, want 1", cl); end
  endtask

  task automatic test_masked_write();
    int lat;
    bit p, st, cl;
    line_acc_req r;
    logic [127:0] exp;
    exp = {64'hAAAAAAAAAAAAAAAA, 32'h55555555, 32'hAAAAAAAA};
    do_write(32'h0000_0100, 16'hFFFF, {16{8'hAA}}, lat, p);
    mdl_write(32'h0000_0100, 16'hFFFF, {16{8'hAA}});
    do_write(32'h0000_0100, 16'h00F0, {16{8'h55}}, lat, p);
    mdl_write(32'h0000_0100, 16'h00F0, {16{8'h55}});
    do_read(32'h0000_0108, 0, lat, r, st, cl);
    n_cmp++;
    if (r.dat !== exp || r.addr !== 32'h100) begin
      n_bad++; $display("FAIL masked_write: got addr=%h dat=%h, want 100 / %h", r.addr, r.dat, exp);
    end
  endtask

  task automatic test_held_response();
    int k, lat;
    bit p, st, no_acc;
    line_acc_req snap;
    logic [127:0] d;
    d = rnd128();
    do_write(32'h0000_0200, 16'hFFFF, d, lat, p);
    mdl_write(32'h0000_0200, 16'hFFFF, d);
    if3.prt_tx_req.addr = 32'h0000_0200; if3.prt_tx_req.rqt = 1'b0;
    if3.prt_tx_rp = 1'b1;
    wait_accept3(k);
    if3.prt_tx_rp = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if3.prt_rx_rp === 1'b1) begin lat = c; break; end
    end
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL held_lat: got %0d, want 3", lat); end
    snap = if3.prt_rx_req;
    // A second request is presented while the response is held.
    if3.prt_tx_req.addr = 32'h0000_0040; if3.prt_tx_rp = 1'b1;
    st = 1'b1; no_acc = 1'b1;
    for (int h = 0; h < 10; h++) begin
      @(posedge clk); #1;
      if (if3.prt_rx_rp !== 1'b1 || if3.prt_rx_req !== snap) st = 1'b0;
      if (if3.prt_tx_ra !== 1'b0) no_acc = 1'b0;
    end
    n_cmp++;
    if (!st || snap.dat !== d) begin
      n_bad++; $display("FAIL held_stable: got stable=%b dat=%h, want 1 / %h", st, snap.dat, d);
    end
    n_cmp++;
    if (!no_acc) begin n_bad++; $display("FAIL held_no_accept: got accept during RESP, want none"); end
    if3.prt_rx_ra = 1'b1;
    @(posedge clk); #1;
    if3.prt_rx_ra = 1'b0;
    n_cmp++;
    if (if3.prt_rx_rp !== 1'b0 || if3.prt_tx_ra !== 1'b0) begin
      n_bad++; $display("FAIL held_release: got rp=%b ra=%b, want 0/0", if3.prt_rx_rp, if3.prt_tx_ra);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (if3.prt_tx_ra !== 1'b1) begin n_bad++; $display("FAIL held_next_accept: got %b, want 1", if3.prt_tx_ra); end
    if3.prt_tx_rp = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if3.prt_rx_rp === 1'b1) begin lat = c; break; end
    end
    n_cmp++;
    if (lat != 3 || if3.prt_rx_req.dat !== mdl_read(32'h40)) begin
      n_bad++; $display("FAIL held_second_read: got lat=%0d dat=%h, want 3 / %h", lat, if3.prt_rx_req.dat, mdl_read(32'h40));
    end
    if3.prt_rx_ra = 1'b1;
    @(posedge clk); #1;
    if3.prt_rx_ra = 1'b0;
  endtask

  task automatic test_out_of_range();
    int lat;
    bit p, st, cl;
    line_acc_req r;
    n_cmp++;
    if (err3 !== 1'b0) begin n_bad++; $display("FAIL oor_err_initial: got %b, want 0", err3); end
    do_read(32'h0000_1000, 0, lat, r, st, cl);
    mdl_err = 1'b1;
    n_cmp++;
    if (r.dat !== 128'd0 || r.addr !== 32'h1000 || err3 !== 1'b1) begin
      n_bad++; $display("FAIL oor_read: got dat=%h addr=%h err=%b, want 0 / 1000 / 1", r.dat, r.addr, err3);
    end
    do_write(32'h0000_1000, 16'hFFFF, rnd128(), lat, p);
    n_cmp++;
    if (lat != 3 || err3 !== 1'b1) begin n_bad++; $display("FAIL oor_write: got lat=%0d err=%b, want 3/1", lat, err3); end
    do_read(32'h0000_0000, 0, lat, r, st, cl);
    n_cmp++;
    if (r.dat !== mdl_read(32'h0) || err3 !== 1'b1) begin
      n_bad++; $display("FAIL oor_no_store_change: got dat=%h err=%b, want %h / 1", r.dat, err3, mdl_read(32'h0));
    end
  endtask

  task automatic test_random();
    int lat, hold;
    bit p, st, cl;
    line_acc_req r;
    logic [31:0] a;
    logic [15:0] m;
    logic [127:0] d;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) a = {$urandom_range(256, 4095), 4'($urandom)};
      else a = {20'd0, 8'($urandom_range(0, 7)), 4'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        m = 16'($urandom); d = rnd128();
        do_write(a, m, d, lat, p);
        mdl_write(a, m, d);
        n_cmp++;
        if (lat != 3 || !p) begin n_bad++; $display("FAIL rnd_write[%0d]: got lat=%0d pulse=%b, want 3/1", it, lat, p); end
      end else begin
        hold = $urandom_range(0, 3);
        do_read(a, hold, lat, r, st, cl);
        if (a[31:4] >= 28'd256) mdl_err = 1'b1;
        n_cmp++;
        if (lat != 3 || r.dat !== mdl_read(a) || r.addr !== {a[31:4], 4'b0000} || !st || !cl) begin
          n_bad++;
          $display("FAIL rnd_read[%0d]: got lat=%0d addr=%h dat=%h st=%b cl=%b, want 3 / %h / %h",
                   it, lat, r.addr, r.dat, st, cl, {a[31:4], 4'b0000}, mdl_read(a));
        end
      end
      n_cmp++;
      if (err3 !== mdl_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b, want %b", it, err3, mdl_err); end
    end
  endtask

  // LATENCY=1 initiator that keeps rp high on the edge after it sees ra.
  task automatic test_latency1();
    int ra0, rsp0, k;
    logic [127:0] d;
    logic [31:0] addrs [2];
    logic [127:0] exps [2];
    d = rnd128();
    ra0 = ra_cnt1; rsp0 = rsp_cnt1;
    if1.prt_tx_req.addr = 32'h30; if1.prt_tx_req.rqt = 1'b1;
    if1.prt_tx_req.wmsk = 16'hFFFF; if1.prt_tx_req.dat = d;
    if1.prt_tx_rp = 1'b1;
    k = -1;
    for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; if (if1.prt_tx_ra === 1'b1) begin k = c; break; end end
    @(posedge clk); #1;
    if1.prt_tx_rp = 1'b0;
    for (int c = 1; c <= 20; c++) begin if (busy1 === 1'b0) break; @(posedge clk); #1; end
    addrs[0] = 32'h30; exps[0] = d;
    addrs[1] = 32'h40; exps[1] = 128'd0;
    for (int n = 0; n < 2; n++) begin
      if1.prt_tx_req.addr = addrs[n]; if1.prt_tx_req.rqt = 1'b0;
      if1.prt_tx_rp = 1'b1;
      k = -1;
      for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; if (if1.prt_tx_ra === 1'b1) begin k = c; break; end end
      @(posedge clk); #1;
      if1.prt_tx_rp = 1'b0;
      n_cmp++;
      if (k <= 0 || if1.prt_rx_rp !== 1'b1 || if1.prt_rx_req.dat !== exps[n]) begin
        n_bad++; $display("FAIL lat1_read[%0d]: got k=%0d rp=%b dat=%h, want rp=1 dat=%h",
                          n, k, if1.prt_rx_rp, if1.prt_rx_req.dat, exps[n]);
      end
      if1.prt_rx_ra = 1'b1;
      @(posedge clk); #1;
      if1.prt_rx_ra = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (ra_cnt1 - ra0 != 3 || rsp_cnt1 - rsp0 != 2) begin
      n_bad++; $display("FAIL lat1_counts: got ra=%0d rsp=%0d, want 3/2", ra_cnt1 - ra0, rsp_cnt1 - rsp0);
    end
  endtask

  initial begin
    if3.prt_tx_rp = 1'b0; if3.prt_tx_req = '0; if3.prt_rx_ra = 1'b0;
    if1.prt_tx_rp = 1'b0; if1.prt_tx_req = '0; if1.prt_rx_ra = 1'b0;
    test_reset();
    test_reset_midflight();
    test_full_write_read();
    test_masked_write();
    test_held_response();
    test_out_of_range();
    test_random();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
